stopwatch_lapbuf: RTL and testbench
===================================

# stopwatch_lapbuf

Parametrised stopwatch/countdown timer with an internal lap memory. It counts up or down in 10 ms steps from an external tick, supports loading a preset time, and stores up to LAP_DEPTH lap snapshots in a circular buffer. The buffer is read back through a registered address/data port. It sits behind the APB slave register file, which drives the command pulses and reads time, status and laps.

## Interface
- LAP_DEPTH, 10: number of lap entries (2..16).
- LAP_AW, 4: lap address width; must satisfy 2**LAP_AW >= LAP_DEPTH.
- HOUR_MAX, 99: highest hour value (1..127); the up-count wraps after HOUR_MAX:59:59.99.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- iPCLK  in  1  clock.
- iRESET  in  1  asynchronous active-high reset.
- iTICK  in  1  one-cycle 10 ms pulse.
- iSTART, iSTOP, iCLEAR, iLAP, iLOAD  in  1 each  single-cycle command pulses.
- iMODE  in  1  count direction: 0 = up, 1 = down. Latched on entry to RUN.
- iLOAD_TIME  in  26  preset time, packed as {hour[6:0], min[5:0], sec[5:0], sub[6:0]}.
- iRD_ADDR  in  LAP_AW  lap read address.
- oRD_DATA  out  26  lap read data.
- oTIME  out  26  current time, same packing as iLOAD_TIME.
- oLAP_WR_ADDR  out  LAP_AW  next lap write slot.
- oLAP_CNT  out  LAP_AW+1  number of valid laps; saturates at LAP_DEPTH.
- oRUNNING  out  1  high in RUN.
- oEXPIRED  out  1  high in EXPIRED.
- oOVF  out  1  sticky up-count wrap flag.
- oMODE  out  1  latched direction.

## Operation
- States: IDLE, RUN, STOP, EXPIRED. Reset state is IDLE.
- Priority in every state: iCLEAR, then iSTOP, then iSTART. iLOAD is independent of the state transitions.
- iCLEAR in any state:
  - time, wr_ptr, lap count and oOVF go to 0;
  - state goes to IDLE.
  - Lap memory contents are not erased.
- IDLE / STOP:
  - iSTART goes to RUN and latches iMODE.
  - If the latched mode is down and time == 0, iSTART goes to EXPIRED instead.
  - iLOAD writes iLOAD_TIME with per-field clamping: sub max 99, sec max 59, min max 59, hour max HOUR_MAX.
  - iLOAD in RUN or EXPIRED is ignored.
- RUN:
  - iSTOP goes to STOP.
  - iSTART is ignored.
  - On iTICK, time advances by one step in the latched direction.
- Up count: BCD-free binary fields.
  - sub wraps 99 to 0 and carries into sec; sec wraps 59 to 0 and carries into min; min wraps 59 to 0 and carries into hour.
  - The increment from HOUR_MAX:59:59.99 gives 0 and sets oOVF. State stays RUN.
- Down count: borrows mirror the up count (sub 0 becomes 99 and borrows, and so on).
  - The tick that reaches 0:00:00.00 also moves to EXPIRED.
- EXPIRED: time holds at 0. Only iCLEAR leaves this state.
- iTICK counts only when the current state is RUN:
  - a tick in the same cycle as iSTOP still counts;
  - a tick in the same cycle as iSTART does not count;
  - iCLEAR overrides a tick.
- Laps:
  - iLAP in RUN or STOP writes mem[wr_ptr] with the oTIME value present in that cycle (before that cycle's tick update).
  - wr_ptr advances and wraps from LAP_DEPTH-1 to 0, so the oldest entry is overwritten.
  - oLAP_CNT increments, saturating at LAP_DEPTH.
  - iLAP in IDLE or EXPIRED is ignored. iLAP together with iCLEAR: no write.
  - iLAP together with iSTOP in RUN: lap is written and state goes to STOP.
- Readback:
  - oRD_DATA = mem[iRD_ADDR], registered.
  - An address >= LAP_DEPTH returns 0.
  - A read and a write to the same address in the same cycle returns the old contents.

## Timing
- Reset values:
  - state IDLE;
  - oTIME, oRD_DATA, oLAP_WR_ADDR and oLAP_CNT are 0;
  - oRUNNING, oEXPIRED, oOVF and oMODE are 0.
  - Lap memory is reset to 0.
- An asserted reset mid-run forces all of the above immediately. Counting resumes only after iSTART once reset is deasserted.
- Commands are sampled on the iPCLK rising edge. State, time and status outputs update on the same edge (1-cycle latency).
- Lap read latency: 1 cycle from iRD_ADDR to oRD_DATA. The lap write is visible to a read issued in the cycle after iLAP.
- oEXPIRED rises on the edge that makes time 0.

## Test plan
- Up rollover:
  - load 0:00:59.99, iSTART, 1 tick: oTIME = 0:01:00.00.
  - load 0:59:59.99, 1 tick: oTIME = 1:00:00.00.
- Countdown:
  - load 0:00:00.03, iMODE=1, iSTART, 3 ticks: oTIME = 0, oEXPIRED = 1, oRUNNING = 0.
  - Further ticks: oTIME stays 0.
  - iCLEAR: state IDLE.
- HOUR_MAX=2:
  - load 2:59:59.99 in up mode, 1 tick: oTIME = 0, oOVF = 1, still running.
  - iCLEAR: oOVF = 0.
- Lap wrap with LAP_DEPTH=4:
  - 6 iLAP pulses at times 1..6: oLAP_CNT = 4, oLAP_WR_ADDR = 2.
  - Reads of addresses 0..3 return 5, 6, 3, 4. Address 7 returns 0.
- Simultaneous events:
  - iSTOP+iTICK+iLAP in RUN at 0.10: lap = 0.10, oTIME = 0.11, state STOP.
  - iCLEAR+iLAP: no write, all counters 0.
  - iSTART+iTICK in STOP: time unchanged.
- Reset mid-run:
  - assert iRESET during RUN at 0:00:05.00: all outputs 0, state IDLE.
  - After deassertion, ticks without iSTART: oTIME stays 0.

Source files
------------

// File: rtl/stopwatch_lapbuf_if.sv
// Command, preset, lap-readback and status bundle between the APB register file
// and the stopwatch core.
interface stopwatch_lapbuf_if #(
    parameter int LAP_AW = 4
);
    logic              iTICK;
    logic              iSTART;
    logic              iSTOP;
    logic              iCLEAR;
    logic              iLAP;
    logic              iLOAD;
    logic              iMODE;
    logic [25:0]       iLOAD_TIME;
    logic [LAP_AW-1:0] iRD_ADDR;
    logic [25:0]       oRD_DATA;
    logic [25:0]       oTIME;
    logic [LAP_AW-1:0] oLAP_WR_ADDR;
    logic [LAP_AW:0]   oLAP_CNT;
    logic              oRUNNING;
    logic              oEXPIRED;
    logic              oOVF;
    logic              oMODE;

    modport master (
        output iTICK, iSTART, iSTOP, iCLEAR, iLAP, iLOAD, iMODE, iLOAD_TIME, iRD_ADDR,
        input  oRD_DATA, oTIME, oLAP_WR_ADDR, oLAP_CNT, oRUNNING, oEXPIRED, oOVF, oMODE
    );

    modport slave (
        input  iTICK, iSTART, iSTOP, iCLEAR, iLAP, iLOAD, iMODE, iLOAD_TIME, iRD_ADDR,
        output oRD_DATA, oTIME, oLAP_WR_ADDR, oLAP_CNT, oRUNNING, oEXPIRED, oOVF, oMODE
    );
endinterface

// File: rtl/stopwatch_lapbuf.sv
// Up/down stopwatch in 10 ms steps with a circular lap snapshot memory and a
// registered lap readback port.
module stopwatch_lapbuf #(
    parameter int LAP_DEPTH = 10,
    parameter int LAP_AW    = 4,
    parameter int HOUR_MAX  = 99
) (
    input logic               iPCLK,
    input logic               iRESET,
    stopwatch_lapbuf_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STOP    = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    typedef struct packed {
        logic [6:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] sub;
    } time_t;

    localparam int                MEM_N      = 1 << LAP_AW;
    localparam logic [6:0]        HOUR_MAX_C = 7'(HOUR_MAX);
    localparam logic [LAP_AW-1:0] LAST_PTR   = LAP_AW'(LAP_DEPTH - 1);
    localparam logic [LAP_AW:0]   DEPTH_CNT  = (LAP_AW + 1)'(LAP_DEPTH);

    state_t            state_r, state_nx_s;
    time_t             time_r, time_nx_s;
    logic              mode_r, mode_nx_s;
    logic              ovf_r, ovf_nx_s;
    logic              running_r, expired_r;
    logic [LAP_AW-1:0] ptr_r, ptr_nx_s;
    logic [LAP_AW:0]   cnt_r, cnt_nx_s;
    logic              lap_we_s;
    logic [26:0]       inc_s;
    time_t             dec_s;
    logic [25:0]       mem_r [MEM_N];
    logic [25:0]       rd_data_r;

    function automatic time_t clamp_time(input time_t t);
        time_t r;
        if (t.sub > 7'd99) r.sub = 7'd99; else r.sub = t.sub;
        if (t.sec > 6'd59) r.sec = 6'd59; else r.sec = t.sec;
        if (t.min > 6'd59) r.min = 6'd59; else r.min = t.min;
        if (t.hour > HOUR_MAX_C) r.hour = HOUR_MAX_C; else r.hour = t.hour;
        return r;
    endfunction

    // Result bit 26 flags the wrap past HOUR_MAX:59:59.99.
    function automatic logic [26:0] inc_time(input time_t t);
        time_t r;
        logic  wrap;
        r    = t;
        wrap = 1'b0;
        if (t.sub != 7'd99) begin
            r.sub = t.sub + 7'd1;
        end else begin
            r.sub = 7'd0;
            if (t.sec != 6'd59) begin
                r.sec = t.sec + 6'd1;
            end else begin
                r.sec = 6'd0;
                if (t.min != 6'd59) begin
                    r.min = t.min + 6'd1;
                end else begin
                    r.min = 6'd0;
                    if (t.hour < HOUR_MAX_C) begin
                        r.hour = t.hour + 7'd1;
                    end else begin
                        r.hour = 7'd0;
                        wrap   = 1'b1;
                    end
                end
            end
        end
        return {wrap, r};
    endfunction

    function automatic time_t dec_time(input time_t t);
        time_t r;
        r = t;
        if (t.sub != 7'd0) begin
            r.sub = t.sub - 7'd1;
        end else begin
            r.sub = 7'd99;
            if (t.sec != 6'd0) begin
                r.sec = t.sec - 6'd1;
            end else begin
                r.sec = 6'd59;
                if (t.min != 6'd0) begin
                    r.min = t.min - 6'd1;
                end else begin
                    r.min = 6'd59;
                    if (t.hour != 7'd0) r.hour = t.hour - 7'd1; else r.hour = 7'd0;
                end
            end
        end
        return r;
    endfunction

    // Next-state, time update and lap pointer bookkeeping.
    always_comb begin
        state_nx_s = state_r;
        time_nx_s  = time_r;
        mode_nx_s  = mode_r;
        ovf_nx_s   = ovf_r;
        ptr_nx_s   = ptr_r;
        cnt_nx_s   = cnt_r;
        lap_we_s   = 1'b0;
        inc_s      = inc_time(time_r);
        dec_s      = dec_time(time_r);
        if (bus.iCLEAR) begin
            state_nx_s = ST_IDLE;
            time_nx_s  = '0;
            ptr_nx_s   = '0;
            cnt_nx_s   = '0;
            ovf_nx_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_STOP: begin
                    if (bus.iLOAD) time_nx_s = clamp_time(bus.iLOAD_TIME);
                    else           time_nx_s = time_r;
                    if (bus.iSTOP) begin
                        state_nx_s = state_r;
                    end else if (bus.iSTART) begin
                        mode_nx_s = bus.iMODE;
                        // A countdown started from zero has nothing to count.
                        if (bus.iMODE && (time_r == '0)) begin
                            state_nx_s = ST_EXPIRED;
                            time_nx_s  = '0;
                        end else begin
                            state_nx_s = ST_RUN;
                        end
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                ST_RUN: begin
                    if (bus.iSTOP) state_nx_s = ST_STOP;
                    else           state_nx_s = ST_RUN;
                    if (!bus.iTICK) begin
                        time_nx_s = time_r;
                    end else if (!mode_r) begin
                        time_nx_s = inc_s[25:0];
                        ovf_nx_s  = ovf_r | inc_s[26];
                    end else if ((time_r == '0) || (dec_s == '0)) begin
                        time_nx_s  = '0;
                        state_nx_s = ST_EXPIRED;
                    end else begin
                        time_nx_s = dec_s;
                    end
                end
                ST_EXPIRED: begin
                    time_nx_s = '0;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    time_nx_s  = '0;
                end
            endcase
            if (bus.iLAP && ((state_r == ST_RUN) || (state_r == ST_STOP))) begin
                lap_we_s = 1'b1;
                ptr_nx_s = (ptr_r == LAST_PTR) ? '0 : ptr_r + LAP_AW'(1);
                cnt_nx_s = (cnt_r == DEPTH_CNT) ? cnt_r : cnt_r + (LAP_AW + 1)'(1);
            end else begin
                lap_we_s = 1'b0;
            end
        end
    end

    // State, time and status registers.
    always_ff @(posedge iPCLK or posedge iRESET) begin
        if (iRESET) begin
            state_r   <= ST_IDLE;
            time_r    <= '0;
            mode_r    <= 1'b0;
            ovf_r     <= 1'b0;
            ptr_r     <= '0;
            cnt_r     <= '0;
            running_r <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            time_r    <= time_nx_s;
            mode_r    <= mode_nx_s;
            ovf_r     <= ovf_nx_s;
            ptr_r     <= ptr_nx_s;
            cnt_r     <= cnt_nx_s;
            running_r <= (state_nx_s == ST_RUN);
            expired_r <= (state_nx_s == ST_EXPIRED);
        end
    end

    // Lap memory; a same-cycle read of the written slot returns the old entry.
    always_ff @(posedge iPCLK or posedge iRESET) begin
        if (iRESET) begin
            for (int i = 0; i < MEM_N; i++) mem_r[i] <= '0;
            rd_data_r <= '0;
        end else begin
            if (lap_we_s) mem_r[ptr_r] <= time_r;
            rd_data_r <= ({1'b0, bus.iRD_ADDR} < DEPTH_CNT) ? mem_r[bus.iRD_ADDR] : 26'd0;
        end
    end

    assign bus.oTIME        = time_r;
    assign bus.oRD_DATA     = rd_data_r;
    assign bus.oLAP_WR_ADDR = ptr_r;
    assign bus.oLAP_CNT     = cnt_r;
    assign bus.oRUNNING     = running_r;
    assign bus.oEXPIRED     = expired_r;
    assign bus.oOVF         = ovf_r;
    assign bus.oMODE        = mode_r;
endmodule

// File: tb/tb_stopwatch_lapbuf.sv
// Directed plus randomized bench for stopwatch_lapbuf; time is modelled as a
// plain centisecond count and laps as a small array.
module tb_stopwatch_lapbuf;
    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int HMAX  = 2;
    localparam int TOTAL = (HMAX + 1) * 360000;
    localparam int S_IDLE = 0, S_RUN = 1, S_STOP = 2, S_EXP = 3;

    logic iPCLK = 1'b0;
    logic iRESET;
    int   tests = 0;
    int   failed = 0;

    int          m_state, m_t, m_ptr, m_cnt;
    logic        m_mode, m_ovf;
    logic [25:0] m_lap [DEPTH];
    logic [25:0] m_rd;

    stopwatch_lapbuf_if #(.LAP_AW(AW)) bus ();

    stopwatch_lapbuf #(.LAP_DEPTH(DEPTH), .LAP_AW(AW), .HOUR_MAX(HMAX)) dut (
        .iPCLK (iPCLK),
        .iRESET(iRESET),
        .bus   (bus.slave)
    );

    always #5 iPCLK = ~iPCLK;

    function automatic logic [25:0] pack(input int t);
        int h, m, s, c;
        h = t / 360000;
        m = (t / 6000) % 60;
        s = (t / 100) % 60;
        c = t % 100;
        return {7'(h), 6'(m), 6'(s), 7'(c)};
    endfunction

    function automatic int clamp_cs(input logic [25:0] v);
        int h, m, s, c;
        h = int'(v[25:19]); m = int'(v[18:13]); s = int'(v[12:7]); c = int'(v[6:0]);
        if (h > HMAX) h = HMAX;
        if (m > 59) m = 59;
        if (s > 59) s = 59;
        if (c > 99) c = 99;
        return ((h * 60 + m) * 60 + s) * 100 + c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_t = 0; m_ptr = 0; m_cnt = 0;
        m_mode = 1'b0; m_ovf = 1'b0; m_rd = 26'd0;
        for (int i = 0; i < DEPTH; i++) m_lap[i] = 26'd0;
    endtask

    task automatic model_update();
        int nt;
        m_rd = (int'(bus.iRD_ADDR) < DEPTH) ? m_lap[int'(bus.iRD_ADDR) % DEPTH] : 26'd0;
        if (bus.iCLEAR) begin
            m_t = 0; m_ptr = 0; m_cnt = 0; m_ovf = 1'b0; m_state = S_IDLE;
        end else begin
            if (bus.iLAP && (m_state == S_RUN || m_state == S_STOP)) begin
                m_lap[m_ptr] = pack(m_t);
                m_ptr = (m_ptr + 1) % DEPTH;
                if (m_cnt < DEPTH) m_cnt++;
            end
            case (m_state)
                S_IDLE, S_STOP: begin
                    nt = bus.iLOAD ? clamp_cs(bus.iLOAD_TIME) : m_t;
                    if (!bus.iSTOP && bus.iSTART) begin
                        m_mode = bus.iMODE;
                        if (bus.iMODE && m_t == 0) begin m_state = S_EXP; nt = 0; end
                        else m_state = S_RUN;
                    end
                    m_t = nt;
                end
                S_RUN: begin
                    if (bus.iSTOP) m_state = S_STOP;
                    if (bus.iTICK) begin
                        if (!m_mode) begin
                            m_t++;
                            if (m_t == TOTAL) begin m_t = 0; m_ovf = 1'b1; end
                        end else begin
                            if (m_t > 0) m_t--;
                            if (m_t == 0) m_state = S_EXP;
                        end
                    end
                end
                default: m_t = 0;
            endcase
        end
    endtask

    task automatic check_model();
        chk("m_time",    32'(bus.oTIME), 32'(pack(m_t)));
        chk("m_running", 32'(bus.oRUNNING), 32'(m_state == S_RUN));
        chk("m_expired", 32'(bus.oEXPIRED), 32'(m_state == S_EXP));
        chk("m_ovf",     32'(bus.oOVF), 32'(m_ovf));
        chk("m_mode",    32'(bus.oMODE), 32'(m_mode));
        chk("m_cnt",     32'(bus.oLAP_CNT), 32'(m_cnt));
        chk("m_wr_addr", 32'(bus.oLAP_WR_ADDR), 32'(m_ptr));
        chk("m_rd_data", 32'(bus.oRD_DATA), 32'(m_rd));
    endtask

    task automatic step();
        model_update();
        @(posedge iPCLK);
        #1;
        check_model();
        bus.iTICK = 1'b0; bus.iSTART = 1'b0; bus.iSTOP = 1'b0;
        bus.iCLEAR = 1'b0; bus.iLAP = 1'b0; bus.iLOAD = 1'b0;
    endtask

    task automatic load(input int h, input int m, input int s, input int c);
        bus.iLOAD_TIME = {7'(h), 6'(m), 6'(s), 7'(c)};
        bus.iLOAD = 1'b1;
        step();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_time"}, 32'(bus.oTIME), 32'd0);
        chk({tag, "_rd"},   32'(bus.oRD_DATA), 32'd0);
        chk({tag, "_wr"},   32'(bus.oLAP_WR_ADDR), 32'd0);
        chk({tag, "_cnt"},  32'(bus.oLAP_CNT), 32'd0);
        chk({tag, "_flags"}, 32'({bus.oRUNNING, bus.oEXPIRED, bus.oOVF, bus.oMODE}), 32'd0);
    endtask

    initial begin
        iRESET = 1'b1;
        bus.iTICK = 1'b0; bus.iSTART = 1'b0; bus.iSTOP = 1'b0; bus.iCLEAR = 1'b0;
        bus.iLAP = 1'b0; bus.iLOAD = 1'b0; bus.iMODE = 1'b0;
        bus.iLOAD_TIME = 26'd0; bus.iRD_ADDR = 3'd0;
        model_reset();
        #12;
        check_zero("reset");
        iRESET = 1'b0;

        // Up-count carries.
        load(0, 0, 59, 99);
        bus.iSTART = 1'b1; step();
        bus.iTICK = 1'b1; step();
        chk("up_sec_carry", 32'(bus.oTIME), 32'({7'd0, 6'd1, 6'd0, 7'd0}));
        bus.iSTOP = 1'b1; step();
        load(0, 59, 59, 99);
        bus.iSTART = 1'b1; step();
        bus.iTICK = 1'b1; step();
        chk("up_min_carry", 32'(bus.oTIME), 32'({7'd1, 6'd0, 6'd0, 7'd0}));

        // Wrap past HOUR_MAX.
        bus.iSTOP = 1'b1; step();
        load(2, 59, 59, 99);
        bus.iSTART = 1'b1; step();
        bus.iTICK = 1'b1; step();
        chk("hour_wrap_time", 32'(bus.oTIME), 32'd0);
        chk("hour_wrap_ovf", 32'(bus.oOVF), 32'd1);
        chk("hour_wrap_run", 32'(bus.oRUNNING), 32'd1);
        bus.iCLEAR = 1'b1; step();
        chk("clear_ovf", 32'(bus.oOVF), 32'd0);

        // Countdown to expiry.
        load(0, 0, 0, 3);
        bus.iMODE = 1'b1; bus.iSTART = 1'b1; step();
        for (int i = 0; i < 3; i++) begin bus.iTICK = 1'b1; step(); end
        chk("cd_time", 32'(bus.oTIME), 32'd0);
        chk("cd_expired", 32'(bus.oEXPIRED), 32'd1);
        chk("cd_running", 32'(bus.oRUNNING), 32'd0);
        chk("cd_mode", 32'(bus.oMODE), 32'd1);
        for (int i = 0; i < 2; i++) begin bus.iTICK = 1'b1; step(); end
        chk("cd_hold", 32'(bus.oTIME), 32'd0);
        bus.iCLEAR = 1'b1; step();
        chk("cd_clear", 32'({bus.oEXPIRED, bus.oRUNNING}), 32'd0);

        // Lap buffer wrap.
        bus.iMODE = 1'b0; bus.iSTART = 1'b1; step();
        for (int k = 1; k <= 6; k++) begin
            bus.iTICK = 1'b1; step();
            bus.iLAP = 1'b1; step();
        end
        chk("lap_cnt", 32'(bus.oLAP_CNT), 32'd4);
        chk("lap_wr", 32'(bus.oLAP_WR_ADDR), 32'd2);
        for (int a = 0; a < 4; a++) begin
            bus.iRD_ADDR = 3'(a); step();
            chk("lap_read", 32'(bus.oRD_DATA), 32'(pack(a < 2 ? a + 5 : a + 1)));
        end
        bus.iRD_ADDR = 3'd7; step();
        chk("lap_read_oob", 32'(bus.oRD_DATA), 32'd0);

        // Simultaneous commands.
        bus.iSTOP = 1'b1; step();
        load(0, 0, 0, 10);
        bus.iSTART = 1'b1; step();
        bus.iSTOP = 1'b1; bus.iTICK = 1'b1; bus.iLAP = 1'b1; step();
        chk("sim_time", 32'(bus.oTIME), 32'(pack(11)));
        chk("sim_stopped", 32'(bus.oRUNNING), 32'd0);
        bus.iRD_ADDR = 3'd2; step();
        chk("sim_lap", 32'(bus.oRD_DATA), 32'(pack(10)));
        bus.iSTART = 1'b1; bus.iTICK = 1'b1; step();
        chk("start_tick_time", 32'(bus.oTIME), 32'(pack(11)));
        bus.iCLEAR = 1'b1; bus.iLAP = 1'b1; step();
        chk("clear_lap_cnt", 32'(bus.oLAP_CNT), 32'd0);
        chk("clear_lap_wr", 32'(bus.oLAP_WR_ADDR), 32'd0);

        // Asynchronous reset mid-run.
        load(0, 0, 5, 0);
        bus.iSTART = 1'b1; step();
        bus.iRD_ADDR = 3'd0;
        iRESET = 1'b1;
        #1;
        model_reset();
        check_zero("midrst");
        @(posedge iPCLK); #1;
        iRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin bus.iTICK = 1'b1; step(); end
        chk("post_rst_time", 32'(bus.oTIME), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            bus.iCLEAR = ($urandom_range(0, 39) == 0);
            bus.iSTOP  = ($urandom_range(0, 11) == 0);
            bus.iSTART = ($urandom_range(0, 7) == 0);
            bus.iLAP   = ($urandom_range(0, 5) == 0);
            bus.iTICK  = ($urandom_range(0, 1) == 0);
            bus.iMODE  = 1'($urandom_range(0, 1));
            bus.iLOAD  = ($urandom_range(0, 9) == 0);
            bus.iRD_ADDR = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0)
                bus.iLOAD_TIME = {19'd0, 7'($urandom_range(0, 6))};
            else
                bus.iLOAD_TIME = {7'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                                  6'($urandom_range(0, 63)), 7'($urandom_range(0, 127))};
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
